mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch port and the MEM-stage data port.
- Data accesses with address bit MMIO_BIT set go to a switch-input / LED-output I/O window and never reach the RAM.
- Arbitrates between the two ports with data priority plus an anti-starvation counter for fetch.
- Sequences each access as issue-then-response and drives the pipeline stall request.

Parameters:
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits; the next grant goes to fetch.
- IO_W, 16, width of the switch input and LED register.
- MMIO_BIT, 31, address bit that selects the I/O window.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- inst_req_i  in  1  fetch request, level, held until inst_ready_o
- inst_addr_i  in  32  fetch address
- inst_data_o  out  32  fetch read data
- inst_ready_o  out  1  one-cycle completion pulse for fetch
- data_ce_i  in  1  data request, level, held until data_ready_o
- data_we_i  in  1  1 = write, 0 = read
- data_addr_i  in  32  data address
- data_wdata_i  in  32  store data
- data_rdata_o  out  32  load data
- data_ready_o  out  1  one-cycle completion pulse for data
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  32  RAM address
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after issue
- switch_i  in  IO_W  board switches
- led_o  out  IO_W  LED register
- stall_o  out  1  pipeline stall request

Behaviour:
- States: IDLE, RESP.
- IDLE arbitration:
  - If data_ce_i and inst_req_i are both high and starve_cnt == STARVE_MAX, grant fetch.
  - Otherwise, if data_ce_i is high, grant data.
  - Otherwise, if inst_req_i is high, grant fetch.
  - Otherwise stay in IDLE.
  - On any grant: record the owner and the MMIO flag, then go to RESP.
- Issue (IDLE cycle with a grant):
  - RAM grant: ram_ce_o=1; ram_addr_o, ram_we_o (data_we_i for data, 0 for fetch) and ram_wdata_o driven combinationally from the winner.
  - MMIO data grant: ram_ce_o=0, ram_we_o=0. A write loads led_o <= data_wdata_i[IO_W-1:0] at this clock edge.
  - Any cycle without an issue: ram_ce_o=0, ram_we_o=0.
- RESP (always exactly one cycle, then IDLE):
  - Owner's ready_o=1.
  - Read result: ram_rdata_i for RAM reads; zero-extended switch_i for MMIO reads.
  - Owner's *_data_o shows the read result combinationally and a hold register captures it at the clock edge.
  - Outside RESP, both *_data_o outputs show their hold registers.
  - Writes still pulse ready; data_rdata_o keeps its previous value on a write.
  - No issue in RESP: a requester cannot lower its request before the edge, so back-to-back grants are not allowed.
  - Throughput: one access per 2 cycles. Load and fetch latency: 2 cycles, request to ready.
- Starve counter (0..STARVE_MAX), updated on each grant:
  - Data grant while inst_req_i is high: +1, saturating.
  - Fetch grant: 0.
  - Data grant while inst_req_i is low: 0.
- stall_o = (inst_req_i & ~inst_ready_o) | (data_ce_i & ~data_ready_o), combinational.
- Reset (rst=0, asynchronous):
  - State IDLE, starve_cnt=0, both hold registers 0, led_o=0.
  - ready pulses 0; ram_ce_o and ram_we_o forced to 0 while rst is low.
- Reset mid-access: any RESP in progress is abandoned and no ready pulse is produced. A RAM write already clocked at issue is not rolled back.
- A request that drops in IDLE before being granted is ignored; no ready is produced.
- Addresses pass through unchanged. Alignment is not checked; byte lanes are outside this block.
- In MMIO reads, bits above IO_W read as 0.

Test Plan:
- Fetch read, RAM[0x100]=0xDEADBEEF, inst_req_i at cycle 0 → ram_ce_o=1 with addr 0x100 at cycle 0; inst_ready_o=1 with inst_data_o=0xDEADBEEF at cycle 1; stall_o high in cycle 0 only; inst_data_o holds the value afterwards.
- Simultaneous fetch 0x0 and load 0x40 at cycle 0 → data granted first (data_ready_o at cycle 1); fetch issued at cycle 2, inst_ready_o at cycle 3.
- Starvation, STARVE_MAX=4, data_ce_i and inst_req_i held high continuously → 4 data grants, then 1 fetch grant, then data resumes; pattern repeats every 10 cycles.
- MMIO: store 0x0000A5A5 to 0x80000000 → ram_ce_o stays 0, led_o=0xA5A5 from the next cycle. Load from 0x80000004 with switch_i=0x1234 → data_rdata_o=0x00001234 with data_ready_o.
- Write then read: store 0xCAFEF00D to 0x200 (ram_we_o=1 at issue, ready one cycle later), then load 0x200 → data_rdata_o=0xCAFEF00D.
- Reset in RESP: assert rst=0 during a fetch RESP → inst_ready_o drops immediately, ram_ce_o=0 and led_o=0. After release with requests still held, arbitration restarts from IDLE with starve_cnt=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between instruction fetch
// and the MEM-stage data port, and decodes a data-side I/O window (switches in,
// LED register out). Every access takes one issue cycle (IDLE) plus one response
// cycle (RESP).
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   inst_*              fetch request/address in; read data and ready pulse out
//   data_*              data request, write enable, address and store data in;
//                       load data and ready pulse out
//   ram_*               chip enable, write enable, address and write data to the
//                       RAM; read data back from it (valid the cycle after issue)
//   switch_i / led_o    I/O window: switch input and LED register
//   stall_o             pipeline stall request
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned IO_W       = 16,
  parameter int unsigned MMIO_BIT   = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req_i,
  input  logic [31:0]     inst_addr_i,
  output logic [31:0]     inst_data_o,
  output logic            inst_ready_o,
  input  logic            data_ce_i,
  input  logic            data_we_i,
  input  logic [31:0]     data_addr_i,
  input  logic [31:0]     data_wdata_i,
  output logic [31:0]     data_rdata_o,
  output logic            data_ready_o,
  output logic            ram_ce_o,
  output logic            ram_we_o,
  output logic [31:0]     ram_addr_o,
  output logic [31:0]     ram_wdata_o,
  input  logic [31:0]     ram_rdata_i,
  input  logic [IO_W-1:0] switch_i,
  output logic [IO_W-1:0] led_o,
  output logic            stall_o
);

  localparam int unsigned      CNT_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_owner_data;
  logic             r_mmio;
  logic             r_we;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [31:0]      r_inst_hold;
  logic [31:0]      r_data_hold;
  logic [IO_W-1:0]  r_led;

  logic             w_grant_inst;
  logic             w_grant_data;
  logic             w_grant_mmio;
  logic             w_inst_ready;
  logic             w_data_ready;
  logic [31:0]      w_rd_result;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Arbitration, issue drive and response decode
  always_comb begin
    w_next_state = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    w_grant_mmio = 1'b0;
    w_inst_ready = 1'b0;
    w_data_ready = 1'b0;
    w_rd_result  = r_mmio ? 32'(switch_i) : ram_rdata_i;
    ram_ce_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_addr_o   = inst_addr_i;
    ram_wdata_o  = data_wdata_i;
    case (r_state)
      S_IDLE: begin
        // A fetch that has watched STARVE_MAX data grants wins over data once.
        if (data_ce_i && inst_req_i && (r_starve_cnt == CNT_MAX)) w_grant_inst = 1'b1;
        else if (data_ce_i)                                         w_grant_data = 1'b1;
        else if (inst_req_i)                                        w_grant_inst = 1'b1;
        if (w_grant_inst || w_grant_data) w_next_state = S_RESP;
      end
      S_RESP: begin
        w_inst_ready = ~r_owner_data;
        w_data_ready = r_owner_data;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    w_grant_mmio = w_grant_data & data_addr_i[MMIO_BIT];
    if (w_grant_data) ram_addr_o = data_addr_i;
    // Gated by rst so nothing reaches the RAM while reset is held.
    ram_ce_o = rst & (w_grant_inst | (w_grant_data & ~w_grant_mmio));
    ram_we_o = rst & w_grant_data & ~w_grant_mmio & data_we_i;
  end

  // Owner / access-type record and fetch starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner_data <= 1'b0;
      r_mmio       <= 1'b0;
      r_we         <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      if (w_grant_inst || w_grant_data) begin
        r_owner_data <= w_grant_data;
        r_mmio       <= w_grant_mmio;
        r_we         <= w_grant_data & data_we_i;
      end
      if (w_grant_inst) begin
        r_starve_cnt <= '0;
      end else if (w_grant_data) begin
        if (!inst_req_i)                  r_starve_cnt <= '0;
        else if (r_starve_cnt != CNT_MAX) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  // Read-data hold registers and LED register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst_hold <= '0;
      r_data_hold <= '0;
      r_led       <= '0;
    end else begin
      if (w_inst_ready)              r_inst_hold <= w_rd_result;
      if (w_data_ready && !r_we)     r_data_hold <= w_rd_result;
      if (w_grant_mmio && data_we_i) r_led       <= data_wdata_i[IO_W-1:0];
    end
  end

  assign inst_ready_o = w_inst_ready;
  assign data_ready_o = w_data_ready;
  assign inst_data_o  = w_inst_ready ? w_rd_result : r_inst_hold;
  // A store response leaves the last load value on data_rdata_o.
  assign data_rdata_o = (w_data_ready && !r_we) ? w_rd_result : r_data_hold;
  assign led_o        = r_led;
  assign stall_o      = (inst_req_i & ~w_inst_ready) | (data_ce_i & ~w_data_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized requesters
// checked against a transaction-level memory/LED reference model.
module tb_mem_arbiter;

  localparam int unsigned IO_W     = 16;
  localparam int unsigned MMIO_BIT = 31;
  localparam logic [31:0] INST_A   = 32'h0000_0000;
  localparam logic [31:0] DATA_A   = 32'h0000_0040;
  localparam int          I_LAT    = 10;
  localparam int          D_LAT    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            inst_req_i;
  logic [31:0]     inst_addr_i;
  logic [31:0]     inst_data_o;
  logic            inst_ready_o;
  logic            data_ce_i;
  logic            data_we_i;
  logic [31:0]     data_addr_i;
  logic [31:0]     data_wdata_i;
  logic [31:0]     data_rdata_o;
  logic            data_ready_o;
  logic            ram_ce_o;
  logic            ram_we_o;
  logic [31:0]     ram_addr_o;
  logic [31:0]     ram_wdata_o;
  logic [31:0]     ram_rdata_i = 32'h0;
  logic [IO_W-1:0] switch_i;
  logic [IO_W-1:0] led_o;
  logic            stall_o;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.STARVE_MAX(4), .IO_W(IO_W), .MMIO_BIT(MMIO_BIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
    .inst_ready_o(inst_ready_o),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_ready_o(data_ready_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .switch_i(switch_i), .led_o(led_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Power-up contents of a word; 0x100 holds the directed fetch pattern.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Single-port synchronous RAM environment, 1024 words.
  logic [31:0] ram_arr [0:1023];
  logic        ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 1024; i++) ram_arr[i] <= init_word(32'(i) << 2);
      ram_init_done <= 1'b1;
    end else if (ram_ce_o) begin
      if (ram_we_o) ram_arr[ram_addr_o[11:2]] <= ram_wdata_o;
      else          ram_rdata_i <= ram_arr[ram_addr_o[11:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both requesters held high: grants alternate issue/response, and every fifth
  // grant (after four data grants) goes to fetch. Starts with the counter at 0.
  task automatic run_pattern(input int n);
    int  k;
    bit  f;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      k = c / 2;
      f = ((k % 5) == 4);
      chk("pat_stall", 32'(stall_o), 32'd1);
      if ((c % 2) == 0) begin
        chk("pat_issue_ce", 32'(ram_ce_o), 32'd1);
        chk("pat_issue_addr", ram_addr_o, f ? INST_A : DATA_A);
        chk("pat_issue_rdy", 32'({inst_ready_o, data_ready_o}), 32'd0);
      end else begin
        chk("pat_resp_ce", 32'(ram_ce_o), 32'd0);
        chk("pat_resp_irdy", 32'(inst_ready_o), 32'(f));
        chk("pat_resp_drdy", 32'(data_ready_o), 32'(!f));
        if (f) chk("pat_resp_idata", inst_data_o, init_word(INST_A));
        else   chk("pat_resp_ddata", data_rdata_o, init_word(DATA_A));
      end
      tick();
    end
  endtask

  // Reference model state for the randomized phase.
  logic [31:0]     ref_mem [0:1023];
  logic [IO_W-1:0] ref_led;
  logic [31:0]     ref_last;
  logic [31:0]     exp_v;
  logic [31:0]     i_addr, d_addr, d_wdata;
  bit              ipend, dpend, d_we, i_done, d_done;
  int              i_wait, d_wait, n_done;

  initial begin
    rst = 1'b1;
    inst_req_i = 1'b0; inst_addr_i = 32'h0;
    data_ce_i = 1'b0; data_we_i = 1'b0; data_addr_i = 32'h0; data_wdata_i = 32'h0;
    switch_i = '0;
    #3 rst = 1'b0;
    @(negedge clk);
    chk("rst_iready", 32'(inst_ready_o), 32'd0);
    chk("rst_dready", 32'(data_ready_o), 32'd0);
    chk("rst_ce", 32'(ram_ce_o), 32'd0);
    chk("rst_led", 32'(led_o), 32'd0);
    chk("rst_idata", inst_data_o, 32'd0);
    chk("rst_ddata", data_rdata_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    tick();

    // Fetch from 0x100.
    inst_req_i = 1'b1; inst_addr_i = 32'h100;
    @(negedge clk);
    chk("f_ce", 32'(ram_ce_o), 32'd1);
    chk("f_we", 32'(ram_we_o), 32'd0);
    chk("f_addr", ram_addr_o, 32'h100);
    chk("f_stall0", 32'(stall_o), 32'd1);
    chk("f_rdy0", 32'(inst_ready_o), 32'd0);
    tick();
    @(negedge clk);
    chk("f_rdy1", 32'(inst_ready_o), 32'd1);
    chk("f_data1", inst_data_o, 32'hDEAD_BEEF);
    chk("f_stall1", 32'(stall_o), 32'd0);
    chk("f_ce1", 32'(ram_ce_o), 32'd0);
    tick();
    inst_req_i = 1'b0;
    @(negedge clk);
    chk("f_rdy2", 32'(inst_ready_o), 32'd0);
    chk("f_hold", inst_data_o, 32'hDEAD_BEEF);
    tick();

    // Simultaneous fetch 0x0 and load 0x40: data first.
    inst_req_i = 1'b1; inst_addr_i = INST_A;
    data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = DATA_A;
    @(negedge clk);
    chk("sim_addr0", ram_addr_o, DATA_A);
    chk("sim_ce0", 32'(ram_ce_o), 32'd1);
    tick();
    @(negedge clk);
    chk("sim_drdy1", 32'(data_ready_o), 32'd1);
    chk("sim_irdy1", 32'(inst_ready_o), 32'd0);
    chk("sim_ddata1", data_rdata_o, init_word(DATA_A));
    chk("sim_stall1", 32'(stall_o), 32'd1);
    tick();
    data_ce_i = 1'b0;
    @(negedge clk);
    chk("sim_ce2", 32'(ram_ce_o), 32'd1);
    chk("sim_addr2", ram_addr_o, INST_A);
    tick();
    @(negedge clk);
    chk("sim_irdy3", 32'(inst_ready_o), 32'd1);
    chk("sim_idata3", inst_data_o, init_word(INST_A));
    tick();

    // Starvation: both held high for 20 cycles.
    data_ce_i = 1'b1;
    run_pattern(20);
    inst_req_i = 1'b0; data_ce_i = 1'b0;
    tick();

    // MMIO store to the LED register, then switch read.
    data_ce_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h8000_0000; data_wdata_i = 32'h0000_A5A5;
    @(negedge clk);
    chk("io_w_ce", 32'(ram_ce_o), 32'd0);
    chk("io_w_we", 32'(ram_we_o), 32'd0);
    chk("io_w_led0", 32'(led_o), 32'd0);
    tick();
    @(negedge clk);
    chk("io_w_led1", 32'(led_o), 32'h0000_A5A5);
    chk("io_w_rdy", 32'(data_ready_o), 32'd1);
    tick();
    data_we_i = 1'b0; data_addr_i = 32'h8000_0004; switch_i = 16'h1234;
    @(negedge clk);
    chk("io_r_ce", 32'(ram_ce_o), 32'd0);
    tick();
    @(negedge clk);
    chk("io_r_rdy", 32'(data_ready_o), 32'd1);
    chk("io_r_data", data_rdata_o, 32'h0000_1234);
    tick();

    // RAM store then load of 0x200.
    data_we_i = 1'b1; data_addr_i = 32'h200; data_wdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    chk("wr_ce", 32'(ram_ce_o), 32'd1);
    chk("wr_we", 32'(ram_we_o), 32'd1);
    chk("wr_addr", ram_addr_o, 32'h200);
    chk("wr_wdata", ram_wdata_o, 32'hCAFE_F00D);
    tick();
    @(negedge clk);
    chk("wr_rdy", 32'(data_ready_o), 32'd1);
    chk("wr_keep", data_rdata_o, 32'h0000_1234);
    tick();
    data_we_i = 1'b0;
    @(negedge clk);
    chk("rd_we", 32'(ram_we_o), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_rdy", 32'(data_ready_o), 32'd1);
    chk("rd_data", data_rdata_o, 32'hCAFE_F00D);
    tick();
    data_ce_i = 1'b0;
    tick();

    // Reset during a fetch response, requests held through reset.
    inst_req_i = 1'b1; inst_addr_i = INST_A; data_addr_i = DATA_A;
    tick();
    @(negedge clk);
    chk("rr_irdy_before", 32'(inst_ready_o), 32'd1);
    #1 rst = 1'b0; data_ce_i = 1'b1;
    #1;
    chk("rr_irdy", 32'(inst_ready_o), 32'd0);
    chk("rr_drdy", 32'(data_ready_o), 32'd0);
    chk("rr_ce", 32'(ram_ce_o), 32'd0);
    chk("rr_we", 32'(ram_we_o), 32'd0);
    chk("rr_led", 32'(led_o), 32'd0);
    chk("rr_idata", inst_data_o, 32'd0);
    @(negedge clk);
    chk("rr_ce_held", 32'(ram_ce_o), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    run_pattern(10);

    // Reset after three data grants must clear the starvation count.
    run_pattern(5);
    @(negedge clk);
    chk("rs_drdy_before", 32'(data_ready_o), 32'd1);
    #1 rst = 1'b0;
    #1 chk("rs_drdy", 32'(data_ready_o), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    run_pattern(10);
    inst_req_i = 1'b0; data_ce_i = 1'b0;
    tick();

    // Randomized requesters against the reference model.
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(32'(i) << 2);
    ref_mem[32'h200 >> 2] = 32'hCAFE_F00D;
    ref_led = '0; ref_last = init_word(DATA_A);
    ipend = 1'b0; dpend = 1'b0; i_wait = 0; d_wait = 0; n_done = 0;
    i_addr = 32'h400; d_addr = 32'h400; d_wdata = 32'h0; d_we = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      i_done = inst_ready_o;
      d_done = data_ready_o;
      chk("rnd_both_rdy", 32'(i_done & d_done), 32'd0);
      if (!i_done && !d_done) chk("rnd_stall", 32'(stall_o), 32'(ipend | dpend));
      if (ram_ce_o) chk("rnd_ram_not_io", 32'(ram_addr_o[MMIO_BIT]), 32'd0);
      if (i_done) begin
        n_done++;
        chk("rnd_i_pend", 32'(ipend), 32'd1);
        chk("rnd_i_data", inst_data_o, ref_mem[i_addr[11:2]]);
        chk("rnd_i_lat", 32'(i_wait <= I_LAT), 32'd1);
      end else if (ipend) i_wait++;
      if (d_done) begin
        n_done++;
        chk("rnd_d_pend", 32'(dpend), 32'd1);
        chk("rnd_d_lat", 32'(d_wait <= D_LAT), 32'd1);
        if (d_we) begin
          if (d_addr[MMIO_BIT]) ref_led = d_wdata[IO_W-1:0];
          else                  ref_mem[d_addr[11:2]] = d_wdata;
          chk("rnd_d_wkeep", data_rdata_o, ref_last);
        end else begin
          exp_v = d_addr[MMIO_BIT] ? 32'(switch_i) : ref_mem[d_addr[11:2]];
          chk("rnd_d_rdata", data_rdata_o, exp_v);
          ref_last = exp_v;
        end
      end else if (dpend) d_wait++;
      chk("rnd_led", 32'(led_o), 32'(ref_led));
      tick();
      if (i_done) ipend = 1'b0;
      if (d_done) dpend = 1'b0;
      if (!ipend && $urandom_range(0, 2) != 0) begin
        ipend = 1'b1; i_wait = 0;
        i_addr = 32'h400 + 32'($urandom_range(0, 7)) * 32'd4;
      end
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend = 1'b1; d_wait = 0;
        d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom();
        if ($urandom_range(0, 3) == 0) d_addr = 32'h8000_0000 + 32'($urandom_range(0, 3)) * 32'd4;
        else                           d_addr = 32'h400 + 32'($urandom_range(0, 7)) * 32'd4;
      end
      inst_req_i = ipend; inst_addr_i = i_addr;
      data_ce_i = dpend; data_we_i = d_we; data_addr_i = d_addr; data_wdata_i = d_wdata;
      switch_i = IO_W'($urandom());
    end
    chk("rnd_i_hang", 32'(i_wait <= I_LAT), 32'd1);
    chk("rnd_d_hang", 32'(d_wait <= D_LAT), 32'd1);
    chk("rnd_progress", 32'(n_done > 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
